// File: rtl/e_mdu_pkg.sv
// Shared xlu_op encodings, default latencies and the long-op decode for the E-stage MDU.
// MDU_MADD_EN adds madd/maddu/msub/msubu to the long-op set.
package e_mdu_pkg;

  localparam logic [3:0] XLU_MULT  = 4'b0000;
  localparam logic [3:0] XLU_MULTU = 4'b0001;
  localparam logic [3:0] XLU_DIV   = 4'b0010;
  localparam logic [3:0] XLU_DIVU  = 4'b0011;
  localparam logic [3:0] XLU_MTHI  = 4'b0100;
  localparam logic [3:0] XLU_MTLO  = 4'b0101;
  localparam logic [3:0] XLU_MFHI  = 4'b0110;
  localparam logic [3:0] XLU_MFLO  = 4'b0111;
  localparam logic [3:0] XLU_NONE  = 4'b1000;
  localparam logic [3:0] XLU_MADD  = 4'b1001;
  localparam logic [3:0] XLU_MADDU = 4'b1010;
  localparam logic [3:0] XLU_MSUB  = 4'b1011;
  localparam logic [3:0] XLU_MSUBU = 4'b1100;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  function automatic logic is_long_op(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      XLU_MULT, XLU_MULTU, XLU_DIV, XLU_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
      XLU_MADD, XLU_MADDU, XLU_MSUB, XLU_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == XLU_DIV) || (op == XLU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit owning HI/LO; long ops hold busy for a fixed cycle count, then commit.
// Optional accumulate ops (madd/maddu/msub/msubu) enabled by MDU_MADD_EN.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        xlu_op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [CNT_W-1:0]  MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [DATA_W-1:0] SMIN      = {1'b1, {(DATA_W-1){1'b0}}};

  logic [3:0]          op_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] prod_s, prod_u;
  logic [DATA_W-1:0]   hi_n, lo_n;

  assign prod_s = {{DATA_W{a_q[DATA_W-1]}}, a_q} * {{DATA_W{b_q[DATA_W-1]}}, b_q};
  assign prod_u = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};

  // Result for the latched op; only sampled on the commit edge.
  always_comb begin
    hi_n = hi;
    lo_n = lo;
    case (op_q)
      XLU_MULT:  {hi_n, lo_n} = prod_s;
      XLU_MULTU: {hi_n, lo_n} = prod_u;
      XLU_DIV: begin
        if (b_q != '0) begin
          if (a_q == SMIN && b_q == {DATA_W{1'b1}}) begin
            lo_n = SMIN;
            hi_n = '0;
          end else begin
            lo_n = $signed(a_q) / $signed(b_q);
            hi_n = $signed(a_q) % $signed(b_q);
          end
        end
      end
      XLU_DIVU: begin
        if (b_q != '0) begin
          lo_n = a_q / b_q;
          hi_n = a_q % b_q;
        end
      end
`ifdef MDU_MADD_EN
      XLU_MADD:  {hi_n, lo_n} = {hi, lo} + prod_s;
      XLU_MADDU: {hi_n, lo_n} = {hi, lo} + prod_u;
      XLU_MSUB:  {hi_n, lo_n} = {hi, lo} - prod_s;
      XLU_MSUBU: {hi_n, lo_n} = {hi, lo} - prod_u;
`endif
      default: begin
        hi_n = hi;
        lo_n = lo;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      hi   <= '0;
      lo   <= '0;
    end else if (busy) begin
      // Any start while busy is dropped; upstream is expected to stall.
      if (cnt == '0) begin
        busy <= 1'b0;
        hi   <= hi_n;
        lo   <= lo_n;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end else if (start) begin
      if (is_long_op(xlu_op)) begin
        busy <= 1'b1;
        op_q <= xlu_op;
        a_q  <= rs_val;
        b_q  <= rt_val;
        cnt  <= is_div_op(xlu_op) ? DIV_LOAD : MULT_LOAD;
      end else if (xlu_op == XLU_MTHI) begin
        hi <= rs_val;
      end else if (xlu_op == XLU_MTLO) begin
        lo <= rs_val;
      end
    end
  end

  always_comb begin
    case (xlu_op)
      XLU_MFHI: rd_data = hi;
      XLU_MFLO: rd_data = lo;
      default:  rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed vector bench for e_mdu: table of single commands plus hand sequences for
// ignored starts, back-to-back issue and reset during an op.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  xlu_op;
  logic [31:0] rs_val, rt_val;
  logic        busy;
  logic [31:0] hi, lo, rd_data;

  int checks = 0;
  int errors = 0;

  e_mdu #(.DATA_W(32), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .xlu_op(xlu_op),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cyc;
  } vec_t;

  vec_t vecs[18];
  int   nv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    xlu_op = op;
    rs_val = a;
    rt_val = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    xlu_op = XLU_NONE;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    nv = 0;
    vecs[nv++] = '{XLU_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[nv++] = '{XLU_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[nv++] = '{XLU_MULT,  32'hFFFFFFFD, 32'hFFFFFFFC, 32'h00000000, 32'h0000000C, 5};
    vecs[nv++] = '{XLU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[nv++] = '{XLU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[nv++] = '{XLU_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[nv++] = '{XLU_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
    vecs[nv++] = '{XLU_MTHI,  32'h11,       32'h0,        32'h00000011, 32'h0000000E, 0};
    vecs[nv++] = '{XLU_MTLO,  32'h22,       32'h0,        32'h00000011, 32'h00000022, 0};
    vecs[nv++] = '{XLU_DIVU,  32'd55,       32'd0,        32'h00000011, 32'h00000022, 10};
    vecs[nv++] = '{XLU_DIV,   32'd55,       32'd0,        32'h00000011, 32'h00000022, 10};
    vecs[nv++] = '{XLU_NONE,  32'h99,       32'h99,       32'h00000011, 32'h00000022, 0};
    vecs[nv++] = '{4'b1111,   32'h99,       32'h99,       32'h00000011, 32'h00000022, 0};
    vecs[nv++] = '{XLU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[nv++] = '{XLU_MTLO,  32'hFFFFFFFF, 32'h0,        32'h00000000, 32'hFFFFFFFF, 0};
`ifdef MDU_MADD_EN
    vecs[nv++] = '{XLU_MADD,  32'd1,        32'd1,        32'h00000001, 32'h00000000, 5};
    vecs[nv++] = '{XLU_MSUB,  32'd1,        32'd1,        32'h00000000, 32'hFFFFFFFF, 5};
`else
    vecs[nv++] = '{XLU_MADD,  32'd1,        32'd1,        32'h00000000, 32'hFFFFFFFF, 0};
    vecs[nv++] = '{XLU_MSUB,  32'd1,        32'd1,        32'h00000000, 32'hFFFFFFFF, 0};
`endif

    reset = 1'b1; start = 1'b0; xlu_op = XLU_NONE; rs_val = '0; rt_val = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("rd_none", rd_data, 32'd0);

    for (int i = 0; i < nv; i++) begin
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
      wait_idle(n);
      check($sformatf("v%0d_cycles", i), n, vecs[i].cyc);
      check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
      xlu_op = XLU_MFHI; #1;
      check($sformatf("v%0d_mfhi", i), rd_data, vecs[i].exp_hi);
      xlu_op = XLU_MFLO; #1;
      check($sformatf("v%0d_mflo", i), rd_data, vecs[i].exp_lo);
      xlu_op = XLU_NONE;
      @(negedge clk);
    end

    // Starts during a divide are dropped; busy length is unchanged.
    issue(XLU_DIV, 32'hFFFFFFF9, 32'd2);
    xlu_op = XLU_MFLO; #1;
    check("busy_rd_old_lo", rd_data, 32'hFFFFFFFF);
    xlu_op = XLU_NONE;
    repeat (2) begin @(posedge clk); #1; end
    issue(XLU_MTLO, 32'h5, 32'h0);
    issue(XLU_MTHI, 32'h9, 32'h0);
    wait_idle(n);
    check("ign_cycles", 4 + n, 10);
    xlu_op = XLU_MFLO; #1;
    check("ign_mflo", rd_data, 32'hFFFFFFFD);
    check("ign_hi", hi, 32'hFFFFFFFF);
    xlu_op = XLU_NONE;

    // Back-to-back: first idle cycle accepts a new command.
    issue(XLU_MULT, 32'd3, 32'd4);
    wait_idle(n);
    check("b2b_first_lo", lo, 32'd12);
    issue(XLU_MULTU, 32'd2, 32'd3);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    check("b2b_cycles", n, 5);
    check("b2b_lo", lo, 32'd6);
    check("b2b_hi", hi, 32'd0);

    // Reset in the middle of a multiply discards it.
    issue(XLU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    repeat (6) begin @(posedge clk); #1; end
    check("rst_late_hi", hi, 32'd0);
    check("rst_late_lo", lo, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
